// File: rtl/usb_proc_pkg.sv
// Shared constants for the USB loopback byte processor: transform modes, control characters, FSM states.
// Pure definitions; no logic, latency or flow control of its own.
package usb_proc_pkg;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_UPPER = 2'd1;
    localparam logic [1:0] MODE_LOWER = 2'd2;
    localparam logic [1:0] MODE_CRLF  = 2'd3;

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_LF_PEND = 1'b1
    } proc_state_t;

endpackage

// File: rtl/usb_sync_fifo.sv
// Synchronous FIFO with registered level and full/empty flags; read data is the head entry, visible combinationally.
// Caller must not push when full or pop when empty; a push is visible at the head one edge later (no bypass).
module usb_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk_48mhz,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_dat,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_dat,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk_48mhz) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/usb_loopback_proc.sv
// Buffered byte transform between USB UART rx and tx streams (PASS/UPPER/LOWER/CR->CRLF); 2-edge latency through an empty FIFO.
// in_ready drops only when the FIFO is full; out_valid/out_data are registered and held until out_ready.
module usb_loopback_proc
    import usb_proc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk_48mhz,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic [1:0]               mode,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         rx_count,
    output logic [CNT_W-1:0]         tx_count
);

    proc_state_t       state;
    proc_state_t       state_nxt;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dat;
    logic              push;
    logic              pop;
    logic              consume;
    logic              load;
    logic [DATA_W-1:0] load_dat;

    // Only the low byte is examined; wider data carries its upper bits through untouched.
    function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] d, input logic [1:0] m);
        logic [DATA_W-1:0] r;
        r = d;
        case (m)
            MODE_UPPER: if (d[7:0] >= 8'h61 && d[7:0] <= 8'h7A) r[7:0] = d[7:0] - 8'h20;
            MODE_LOWER: if (d[7:0] >= 8'h41 && d[7:0] <= 8'h5A) r[7:0] = d[7:0] + 8'h20;
            default:    r = d;
        endcase
        return r;
    endfunction

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    usb_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_48mhz (clk_48mhz),
        .reset_n   (reset_n),
        .push      (push),
        .push_dat  (in_data),
        .pop       (pop),
        .pop_dat   (fifo_dat),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (pop && mode == MODE_CRLF && fifo_dat[7:0] == CH_CR) state_nxt = ST_LF_PEND;
            ST_LF_PEND: if (consume) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // LF_PEND blocks the FIFO and swaps in the LF once the CR leaves.
    always_comb begin
        pop      = 1'b0;
        load     = 1'b0;
        load_dat = '0;
        case (state)
            ST_IDLE: begin
                if ((!out_valid || consume) && !fifo_empty) begin
                    pop      = 1'b1;
                    load     = 1'b1;
                    load_dat = xform(fifo_dat, mode);
                end
            end
            ST_LF_PEND: begin
                if (consume) begin
                    load          = 1'b1;
                    load_dat[7:0] = CH_LF;
                end
            end
            default: begin
                pop  = 1'b0;
                load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= load_dat;
            out_valid <= 1'b1;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            rx_count <= '0;
            tx_count <= '0;
        end else begin
            if (push) begin
                rx_count <= rx_count + 1'b1;
            end
            if (consume) begin
                tx_count <= tx_count + 1'b1;
            end
        end
    end

endmodule
